// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and bus widths for the two-port memory write arbiter.
// No logic here; imported by mem_arb_pick and mem_arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    function automatic logic [1:0] own_of(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: locked owner first, then lone requester, then tie-break.
// Purely combinational; grant is only ever raised alongside its request.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_lock0,
    input  logic       i_lock1,
    input  logic [1:0] i_own,
    input  logic [7:0] i_cnt,
    input  logic       i_last,
    output logic       o_win_vld,
    output logic       o_win,
    output logic       o_gnt0,
    output logic       o_gnt1
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    logic w_hold0;
    logic w_hold1;
    logic w_tie_win;

`ifdef MEM_ARB_RR_EN
    assign w_tie_win = ~i_last;
`else
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign w_tie_win     = 1'b0;
`endif

    // Lock is honoured only while the burst is below the cap.
    assign w_hold0 = (i_own == OWN0) && i_req0 && i_lock0 && (i_cnt < MAX_B);
    assign w_hold1 = (i_own == OWN1) && i_req1 && i_lock1 && (i_cnt < MAX_B);

    always_comb begin
        o_win = 1'b0;
        if (w_hold0)
            o_win = 1'b0;
        else if (w_hold1)
            o_win = 1'b1;
        else if (i_req0 ^ i_req1)
            o_win = i_req1;
        else
            o_win = w_tie_win;
    end

    assign o_win_vld = i_req0 | i_req1;
    assign o_gnt0    = o_win_vld & ~o_win;
    assign o_gnt1    = o_win_vld &  o_win;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port write arbiter into mem_ctrl; MEM_ARB_RR_EN selects round-robin ties (else port 0 wins).
// Latency: transfer at edge k appears on mem_* from k to k+1; one transfer per cycle.
// Backpressure: a requester holds req/addr/data/lock until the edge where its gnt is high.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    logic [1:0]        r_own;
    logic [7:0]        r_cnt;
    logic              r_last;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_we;

    logic              w_win_vld;
    logic              w_win;
    logic              w_lock;
    logic [1:0]        w_own_win;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .i_req0    (req0),
        .i_req1    (req1),
        .i_lock0   (lock0),
        .i_lock1   (lock1),
        .i_own     (r_own),
        .i_cnt     (r_cnt),
        .i_last    (r_last),
        .o_win_vld (w_win_vld),
        .o_win     (w_win),
        .o_gnt0    (gnt0),
        .o_gnt1    (gnt1)
    );

    assign w_lock    = w_win ? lock1 : lock0;
    assign w_addr    = w_win ? addr1 : addr0;
    assign w_data    = w_win ? data1 : data0;
    assign w_own_win = own_of(w_win);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_own      <= IDLE;
            r_cnt      <= 8'd0;
            r_last     <= 1'b1;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
        end else if (w_win_vld) begin
            r_mem_addr <= w_addr;
            r_mem_data <= w_data;
            r_mem_we   <= 1'b1;
            r_last     <= w_win;
            if (w_lock) begin
                r_own <= w_own_win;
                // A capped or newly started burst counts this transfer as its first.
                r_cnt <= ((r_own == w_own_win) && (r_cnt < MAX_B)) ? r_cnt + 8'd1 : 8'd1;
            end else begin
                r_own <= IDLE;
                r_cnt <= 8'd0;
            end
        end else begin
            r_mem_we <= 1'b0;
            r_own    <= IDLE;
            r_cnt    <= 8'd0;
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MAX_BURST=4; expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0, req1, lock0, lock1;
    logic [31:0] addr0, addr1, data0, data1;
    logic        gnt0, gnt1;
    logic [31:0] mem_addr, mem_data;
    logic        mem_we;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MEM_ARB_RR_EN
    int cont_win[4]  = '{0, 1, 0, 1};
    int burst_win[6] = '{0, 0, 0, 0, 1, 0};
    int burst_cnt[6] = '{1, 2, 3, 4, 0, 1};
`else
    int cont_win[4]  = '{0, 0, 0, 0};
    int burst_win[6] = '{0, 0, 0, 0, 0, 0};
    int burst_cnt[6] = '{1, 2, 3, 4, 1, 2};
`endif
    int cap_cnt[5] = '{1, 2, 3, 4, 1};

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .lock0    (lock0),
        .lock1    (lock1),
        .addr0    (addr0),
        .addr1    (addr1),
        .data0    (data0),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_we", {31'd0, mem_we}, 32'd0);
            chk("rst_addr", mem_addr, 32'd0);
            chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        end
        rst = 1'b0;
        chk("rst_own", {30'd0, dut.r_own}, {30'd0, IDLE});
        chk("rst_cnt", {24'd0, dut.r_cnt}, 32'd0);
        chk("rst_last", {31'd0, dut.r_last}, 32'd1);
        tick();
        chk("idle_we", {31'd0, mem_we}, 32'd0);
        chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // Single write
        req0 = 1; addr0 = 32'h10; data0 = 32'hA5A5;
        #1;
        chk("single_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        tick();
        req0 = 0;
        chk("single_we", {31'd0, mem_we}, 32'd1);
        chk("single_addr", mem_addr, 32'h10);
        chk("single_data", mem_data, 32'hA5A5);
        tick();
        chk("single_we_drop", {31'd0, mem_we}, 32'd0);
        chk("single_addr_hold", mem_addr, 32'h10);

        // Contention after a mid-cycle reset pulse
        rst = 1; #2; rst = 0;
        chk("cont_last", {31'd0, dut.r_last}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            req0 = 1; req1 = 1;
            addr0 = 32'h100 + i; data0 = 32'hD000 + i;
            addr1 = 32'h200 + i; data1 = 32'hE000 + i;
            #1;
            chk("cont_gnt", {30'd0, gnt1, gnt0}, (cont_win[i] == 1) ? 32'd2 : 32'd1);
            tick();
            chk("cont_we", {31'd0, mem_we}, 32'd1);
            chk("cont_addr", mem_addr, (cont_win[i] == 1) ? 32'h200 + i : 32'h100 + i);
            chk("cont_data", mem_data, (cont_win[i] == 1) ? 32'hE000 + i : 32'hD000 + i);
        end
        req0 = 0; req1 = 0;
        tick();
        chk("cont_we_drop", {31'd0, mem_we}, 32'd0);

        // Locked burst against a competing port 1
        addr1 = 32'h300; data1 = 32'hF300; req1 = 1; lock1 = 0;
        for (int i = 0; i < 6; i++) begin
            req0 = 1; lock0 = 1;
            addr0 = 32'h400 + i; data0 = 32'hC400 + i;
            #1;
            chk("burst_gnt", {30'd0, gnt1, gnt0}, (burst_win[i] == 1) ? 32'd2 : 32'd1);
            tick();
            chk("burst_addr", mem_addr, (burst_win[i] == 1) ? 32'h300 : 32'h400 + i);
            chk("burst_cnt", {24'd0, dut.r_cnt}, burst_cnt[i]);
        end

        // Owner drops req while locked
        req0 = 0; lock0 = 0;
        #1;
        chk("drop_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        tick();
        chk("drop_own", {30'd0, dut.r_own}, {30'd0, IDLE});
        chk("drop_cnt", {24'd0, dut.r_cnt}, 32'd0);
        chk("drop_addr", mem_addr, 32'h300);

        // Lone locked owner at the cap re-wins and restarts the count
        for (int i = 0; i < 5; i++) begin
            req1 = 1; lock1 = 1;
            addr1 = 32'h500 + i; data1 = 32'hB500 + i;
            #1;
            chk("cap_gnt", {30'd0, gnt1, gnt0}, 32'd2);
            tick();
            chk("cap_cnt", {24'd0, dut.r_cnt}, cap_cnt[i]);
            chk("cap_addr", mem_addr, 32'h500 + i);
        end

        // Asynchronous reset mid-burst
        req0 = 1; lock0 = 0; addr0 = 32'h600; data0 = 32'hA600;
        chk("arst_pre_we", {31'd0, mem_we}, 32'd1);
        #1 rst = 1;
        #1;
        chk("arst_we", {31'd0, mem_we}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_own", {30'd0, dut.r_own}, {30'd0, IDLE});
        tick();
        chk("arst_hold_we", {31'd0, mem_we}, 32'd0);
        rst = 0; lock1 = 0;
        #1;
        chk("arst_tie_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        tick();
        chk("arst_tie_addr", mem_addr, 32'h600);
        chk("arst_tie_we", {31'd0, mem_we}, 32'd1);
        req0 = 0; req1 = 0;
        tick();
        chk("end_we", {31'd0, mem_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
